// File: rtl/alu_mc_responder.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith ops plus an iterative
// shift-add unsigned multiply, all returned on one registered valid/ready channel.
module alu_mc_responder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       ALUCont,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             zero,
   output logic             ovf
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_NOR = 4'b1100;

   localparam int          CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_ovf;

   // Single-cycle datapath, evaluated on the live request inputs so the
   // result can be registered on the accept edge itself.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (ALUCont)
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_NOR: alu_res = ~(A | B);
         OP_ADD: begin
            alu_res = A + B;
            alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = A - B;
            alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         default: begin
            alu_res = '0;
            alu_ovf = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         ALUResult <= '0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!req_ready) begin
                  req_ready <= 1'b1;
               end else if (req_valid) begin
                  req_ready <= 1'b0;
                  if (ALUCont == OP_MUL) begin
                     acc    <= '0;
                     mcand  <= {{WIDTH{1'b0}}, A};
                     mplier <= B;
                     cnt    <= '0;
                     state  <= EXEC;
                  end else begin
                     ALUResult <= alu_res;
                     zero      <= (alu_res == '0);
                     ovf       <= alu_ovf;
                     rsp_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            EXEC: begin
               // One extra edge after the last iteration to publish the product.
               if (cnt == CNT_LAST) begin
                  ALUResult <= acc[WIDTH-1:0];
                  zero      <= (acc[WIDTH-1:0] == '0);
                  ovf       <= |acc[2*WIDTH-1:WIDTH];
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  if (mplier[0]) acc <= acc + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc_responder.sv
// Directed bench for alu_mc_responder: reference model plus a per-cycle
// response comparator, latency and handshake checks.
module tb_alu_mc_responder;

   localparam int W = 32;

   localparam logic [3:0] C_AND = 4'b0000;
   localparam logic [3:0] C_OR  = 4'b0001;
   localparam logic [3:0] C_ADD = 4'b0010;
   localparam logic [3:0] C_SUB = 4'b0110;
   localparam logic [3:0] C_SLT = 4'b0111;
   localparam logic [3:0] C_MUL = 4'b1000;
   localparam logic [3:0] C_NOR = 4'b1100;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [3:0]   ALUCont = '0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] ALUResult;
   logic         zero;
   logic         ovf;

   int tests = 0;
   int fails = 0;

   logic [W-1:0] m_res;
   logic         m_ovf;
   logic         exp_live = 1'b0;

   alu_mc_responder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .ALUCont(ALUCont), .A(A), .B(B),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .ALUResult(ALUResult), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference: plain wide arithmetic, overflow judged by range of the exact result.
   function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, s;
      logic [63:0] p;
      logic [W-1:0] r;
      logic o;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = '0;
      o = 1'b0;
      case (op)
         C_AND: r = a & b;
         C_OR:  r = a | b;
         C_NOR: r = ~(a | b);
         C_ADD: begin
            s = sa + sb;
            r = W'(s);
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         C_SUB: begin
            s = sa - sb;
            r = W'(s);
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         C_SLT: r = (sa < sb) ? 1 : 0;
         C_MUL: begin
            p = {32'd0, a} * {32'd0, b};
            r = p[31:0];
            o = (p[63:32] != 0);
         end
         default: r = '0;
      endcase
      return {o, r};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Every cycle a response is presented, it must match the model for the accepted op.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && exp_live) begin
         check("rsp.ALUResult", 64'(ALUResult), 64'(m_res));
         check("rsp.ovf", 64'(ovf), 64'(m_ovf));
         check("rsp.zero", 64'(zero), 64'(m_res == '0));
         check("rsp.req_ready_low", 64'(req_ready), 64'd0);
      end
      if (rst_n && exp_live && !rsp_valid && req_ready)
         check("no_rsp_while_ready", 64'(req_ready), 64'd0);
   end

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_ready_timeout", 64'(req_ready), 64'd1);
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      wait_ready();
      req_valid = 1'b1;
      ALUCont = op;
      A = a;
      B = b;
      {m_ovf, m_res} = model(op, a, b);
      @(posedge clk); #1;
      exp_live = 1'b1;
      req_valid = 1'b0;
      ALUCont = 4'($urandom);
      A = $urandom;
      B = $urandom;
      check("req_ready_after_accept", 64'(req_ready), 64'd0);
   endtask

   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int exp_edges);
      int n = 0;
      issue(op, a, b);
      while (!rsp_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 64'(n), 64'(exp_edges));
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      exp_live = 1'b0;
      check("hs.rsp_valid", 64'(rsp_valid), 64'd0);
      check("hs.req_ready", 64'(req_ready), 64'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #3;
      check("rst.req_ready", 64'(req_ready), 64'd0);
      check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst.ALUResult", 64'(ALUResult), 64'd0);
      check("rst.zero", 64'(zero), 64'd0);
      check("rst.ovf", 64'(ovf), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst.ready_before_edge", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      check("rst.ready_first_edge", 64'(req_ready), 64'd1);

      // Pin the model with hand-computed values
      check("model.add", 64'(model(C_ADD, 32'h11111111, 32'h22222222)), {31'd0, 1'b0, 32'h33333333});
      check("model.sub", 64'(model(C_SUB, 32'hBEEFFEEB, 32'hDEADDEAD)), {31'd0, 1'b0, 32'hE042203E});
      check("model.addovf", 64'(model(C_ADD, 32'h7FFFFFFF, 32'h1)), {31'd0, 1'b1, 32'h80000000});
      check("model.mul", 64'(model(C_MUL, 32'h00010000, 32'h00010000)), {31'd0, 1'b1, 32'h0});

      do_op(C_ADD, 32'h11111111, 32'h22222222, 0);
      check("add.res", 64'(ALUResult), 64'h33333333);
      check("add.zero", 64'(zero), 64'd0);
      check("add.ovf", 64'(ovf), 64'd0);
      finish_rsp();

      do_op(C_SUB, 32'hBEEFFEEB, 32'hDEADDEAD, 0);
      check("sub.res", 64'(ALUResult), 64'hE042203E);
      check("sub.ovf", 64'(ovf), 64'd0);
      finish_rsp();

      do_op(C_SLT, 32'hBEEFFEEB, 32'hDEADDEAD, 0);
      check("slt.res", 64'(ALUResult), 64'd1);
      finish_rsp();

      do_op(C_ADD, 32'h7FFFFFFF, 32'h00000001, 0);
      check("addovf.res", 64'(ALUResult), 64'h80000000);
      check("addovf.ovf", 64'(ovf), 64'd1);
      finish_rsp();

      do_op(C_NOR, 32'hFFFFFFFF, 32'h0, 0);
      check("nor.res", 64'(ALUResult), 64'd0);
      check("nor.zero", 64'(zero), 64'd1);
      finish_rsp();

      do_op(C_SUB, 32'h80000000, 32'h1, 0);
      check("subovf.ovf", 64'(ovf), 64'd1);
      finish_rsp();

      do_op(C_AND, 32'hF0F0A5A5, 32'h0FF0FF00, 0);
      finish_rsp();
      do_op(C_OR, 32'hF0F0A5A5, 32'h0FF0FF00, 0);
      finish_rsp();

      do_op(C_MUL, 32'h00010000, 32'h00010000, W + 1);
      check("mul.res", 64'(ALUResult), 64'd0);
      check("mul.zero", 64'(zero), 64'd1);
      check("mul.ovf", 64'(ovf), 64'd1);
      finish_rsp();

      do_op(C_MUL, 32'd7, 32'd6, W + 1);
      check("mul76.res", 64'(ALUResult), 64'h2A);
      check("mul76.ovf", 64'(ovf), 64'd0);
      finish_rsp();

      do_op(C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, W + 1);
      finish_rsp();

      // Illegal opcode completes in one cycle with a zero result
      do_op(4'b0011, 32'h12345678, 32'h9ABCDEF0, 0);
      check("ill.zero", 64'(zero), 64'd1);
      check("ill.ovf", 64'(ovf), 64'd0);
      finish_rsp();

      // Backpressure: response frozen, new requests ignored
      do_op(C_ADD, 32'd100, 32'd23, 0);
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1;
         ALUCont = C_SUB;
         A = $urandom;
         B = $urandom;
         @(posedge clk); #1;
         check("bp.res", 64'(ALUResult), 64'd123);
         check("bp.valid", 64'(rsp_valid), 64'd1);
         check("bp.req_ready", 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      finish_rsp();
      @(posedge clk); #1;
      check("bp.no_requeue", 64'(rsp_valid), 64'd0);

      // Reset in the middle of a multiply
      issue(C_MUL, 32'd9, 32'd9);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_live = 1'b0;
      #1;
      check("rstmul.req_ready", 64'(req_ready), 64'd0);
      check("rstmul.rsp_valid", 64'(rsp_valid), 64'd0);
      check("rstmul.ALUResult", 64'(ALUResult), 64'd0);
      check("rstmul.zero", 64'(zero), 64'd0);
      check("rstmul.ovf", 64'(ovf), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rstmul.ready_before_edge", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      check("rstmul.ready_after_edge", 64'(req_ready), 64'd1);
      repeat (40) begin
         @(posedge clk); #1;
         if (rsp_valid) check("rstmul.stale_rsp", 64'(rsp_valid), 64'd0);
      end

      do_op(C_ADD, 32'd2, 32'd3, 0);
      check("post.res", 64'(ALUResult), 64'd5);
      finish_rsp();

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
